rec_play_sequencer: RTL and testbench

REC_PLAY_SEQUENCER -- requirements
Module: rec_play_sequencer

---
 rtl/rec_play_sequencer.sv | 160 ++++++++++++++++
 tb/tb_rec_play_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_play_sequencer.sv
// Record/playback sequencer: stores ADC samples into a sample memory on each
// sample tick and loops them back to the DAC, with overrun and full tracking.
module rec_play_sequencer #(
    parameter int unsigned       ADDR_W   = 25,
    parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DO_RECORD,
    input  logic              DO_PLAYBACK,
    input  logic              DO_CLEAR,
    input  logic              SAMPLE_TICK,
    input  logic [15:0]       ADC_DATA,
    output logic [15:0]       DAC_DATA,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    input  logic [15:0]       MEM_RDATA,
    input  logic              MEM_ACK,
    output logic [ADDR_W-1:0] REC_TIME,
    output logic [ADDR_W-1:0] REC_END_TIME,
    output logic              BUSY,
    output logic              FULL,
    output logic              OVERRUN
);

    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        REC_WAIT,
        REC_WRITE,
        PLAY_WAIT,
        PLAY_READ,
        CLEAR
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   rec_time_nxt, rec_end_nxt, addr_nxt, time_inc_c;
    logic [DATA_W-1:0]   wdata_nxt, dac_nxt;
    logic                req_nxt, we_nxt, full_nxt, ovr_nxt;
    logic                clr_block, clr_block_nxt;
    logic                ack_c;

    // Acks are only meaningful while a request is outstanding
    assign ack_c      = MEM_REQ & MEM_ACK;
    assign time_inc_c = REC_TIME + ADDR_W'(1);

    always_comb begin
        state_nxt    = state;
        rec_time_nxt = REC_TIME;
        rec_end_nxt  = REC_END_TIME;
        addr_nxt     = MEM_ADDR;
        wdata_nxt    = MEM_WDATA;
        dac_nxt      = DAC_DATA;
        req_nxt      = MEM_REQ;
        we_nxt       = MEM_WE;
        full_nxt     = FULL;
        ovr_nxt      = OVERRUN;

        case (state)
            IDLE: begin
                if (DO_CLEAR && !clr_block) begin
                    state_nxt    = CLEAR;
                    rec_time_nxt = '0;
                    rec_end_nxt  = '0;
                    full_nxt     = 1'b0;
                    ovr_nxt      = 1'b0;
                end else if (DO_RECORD) begin
                    state_nxt    = REC_WAIT;
                    rec_time_nxt = '0;
                end else if (DO_PLAYBACK) begin
                    state_nxt    = PLAY_WAIT;
                    rec_time_nxt = '0;
                end
            end
            REC_WAIT: begin
                if (!DO_RECORD) begin
                    state_nxt = IDLE;
                end else if (SAMPLE_TICK && !FULL) begin
                    state_nxt = REC_WRITE;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = REC_TIME;
                    wdata_nxt = ADC_DATA;
                end
            end
            REC_WRITE: begin
                if (SAMPLE_TICK) ovr_nxt = 1'b1;
                if (ack_c) begin
                    state_nxt   = REC_WAIT;
                    req_nxt     = 1'b0;
                    we_nxt      = 1'b0;
                    rec_end_nxt = time_inc_c;
                    if (REC_TIME == MAX_ADDR) full_nxt = 1'b1;
                    else                      rec_time_nxt = time_inc_c;
                end
            end
            PLAY_WAIT: begin
                if (!DO_PLAYBACK) begin
                    state_nxt = IDLE;
                end else if (SAMPLE_TICK && (REC_END_TIME != '0)) begin
                    state_nxt = PLAY_READ;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = REC_TIME;
                end
            end
            PLAY_READ: begin
                if (SAMPLE_TICK) ovr_nxt = 1'b1;
                if (ack_c) begin
                    state_nxt    = PLAY_WAIT;
                    req_nxt      = 1'b0;
                    dac_nxt      = MEM_RDATA;
                    rec_time_nxt = (time_inc_c == REC_END_TIME) ? '0 : time_inc_c;
                end
            end
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // The DAC only carries audio while playback is active
        if (!(state_nxt inside {PLAY_WAIT, PLAY_READ})) dac_nxt = '0;

        // A held DO_CLEAR clears once; it must drop before clearing again
        clr_block_nxt = DO_CLEAR && (clr_block || (state_nxt == CLEAR));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            REC_TIME     <= '0;
            REC_END_TIME <= '0;
            MEM_ADDR     <= '0;
            MEM_WDATA    <= '0;
            DAC_DATA     <= '0;
            MEM_REQ      <= 1'b0;
            MEM_WE       <= 1'b0;
            FULL         <= 1'b0;
            OVERRUN      <= 1'b0;
            BUSY         <= 1'b0;
            clr_block    <= 1'b0;
        end else begin
            state        <= state_nxt;
            REC_TIME     <= rec_time_nxt;
            REC_END_TIME <= rec_end_nxt;
            MEM_ADDR     <= addr_nxt;
            MEM_WDATA    <= wdata_nxt;
            DAC_DATA     <= dac_nxt;
            MEM_REQ      <= req_nxt;
            MEM_WE       <= we_nxt;
            FULL         <= full_nxt;
            OVERRUN      <= ovr_nxt;
            BUSY         <= (state_nxt != IDLE);
            clr_block    <= clr_block_nxt;
        end
    end

endmodule

// File: tb/tb_rec_play_sequencer.sv
// Bench for rec_play_sequencer: vector table, directed corner sequences and
// randomized sessions checked against a transaction-level model.
module tb_rec_play_sequencer;

    localparam int unsigned AW = 8;
    localparam logic [AW-1:0] MAXA = 8'd3;

    logic CLK = 1'b0;
    logic RESET, DO_RECORD, DO_PLAYBACK, DO_CLEAR, SAMPLE_TICK, MEM_ACK;
    logic [15:0] ADC_DATA, MEM_RDATA, DAC_DATA, MEM_WDATA;
    logic MEM_REQ, MEM_WE, BUSY, FULL, OVERRUN;
    logic [AW-1:0] MEM_ADDR, REC_TIME, REC_END_TIME;

    int errors = 0;
    int checks = 0;

    rec_play_sequencer #(.ADDR_W(AW), .MAX_ADDR(MAXA)) dut (
        .CLK(CLK), .RESET(RESET),
        .DO_RECORD(DO_RECORD), .DO_PLAYBACK(DO_PLAYBACK), .DO_CLEAR(DO_CLEAR),
        .SAMPLE_TICK(SAMPLE_TICK), .ADC_DATA(ADC_DATA), .DAC_DATA(DAC_DATA),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
        .REC_TIME(REC_TIME), .REC_END_TIME(REC_END_TIME),
        .BUSY(BUSY), .FULL(FULL), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs at a falling edge; return at the next falling edge
    task automatic drive(input int rec, input int play, input int clr, input int tick,
                         input int ack, input int adc, input int rd);
        DO_RECORD   = 1'(rec);
        DO_PLAYBACK = 1'(play);
        DO_CLEAR    = 1'(clr);
        SAMPLE_TICK = 1'(tick);
        MEM_ACK     = 1'(ack);
        ADC_DATA    = 16'(adc);
        MEM_RDATA   = 16'(rd);
        @(negedge CLK);
    endtask

    typedef struct {
        logic rec, play, tick, ack;
        logic [15:0] rd;
        logic req, we;
        logic [7:0] addr;
        logic [15:0] dac;
        logic [7:0] endt;
        logic busy;
    } vec_t;

    function automatic vec_t row(input int rec, input int play, input int tick, input int ack,
                                 input int rd, input int req, input int we, input int addr,
                                 input int dac, input int endt, input int busy);
        vec_t v;
        v.rec = 1'(rec);   v.play = 1'(play); v.tick = 1'(tick); v.ack = 1'(ack);
        v.rd  = 16'(rd);   v.req  = 1'(req);  v.we   = 1'(we);   v.addr = 8'(addr);
        v.dac = 16'(dac);  v.endt = 8'(endt); v.busy = 1'(busy);
        return v;
    endfunction

    // Transaction-level reference model
    typedef enum int {M_IDLE, M_CLEAR, M_REC, M_PLAY} mode_t;
    mode_t       m_mode;
    int          m_len, m_wcnt, m_ptr, m_addr, lat;
    bit          m_full, m_ovr, m_pend, m_blk, m_we, lat_on;
    logic [15:0] m_wdata, m_dac;
    logic [15:0] m_rec [4];
    logic [15:0] mem [256];

    task automatic rstep(input logic rec, input logic play, input logic clr,
                         input logic tick, input logic [15:0] adc);
        logic ack;
        logic [15:0] rd;
        bit pb, enter_clr;
        chk("rnd.req", 32'(MEM_REQ), 32'(m_pend));
        chk("rnd.busy", 32'(BUSY), 32'(m_mode != M_IDLE));
        chk("rnd.end", 32'(REC_END_TIME), m_len);
        chk("rnd.full", 32'(FULL), 32'(m_full));
        chk("rnd.ovr", 32'(OVERRUN), 32'(m_ovr));
        chk("rnd.dac", 32'(DAC_DATA), 32'(m_dac));
        if (m_pend) begin
            chk("rnd.we", 32'(MEM_WE), 32'(m_we));
            chk("rnd.addr", 32'(MEM_ADDR), m_addr);
            if (m_we) chk("rnd.wdata", 32'(MEM_WDATA), 32'(m_wdata));
        end
        ack = 1'b0;
        rd  = 16'h0;
        if (MEM_REQ) begin
            if (!lat_on) begin lat_on = 1'b1; lat = $urandom_range(0, 2); end
            if (lat == 0) begin
                ack = 1'b1;
                lat_on = 1'b0;
                rd = mem[MEM_ADDR];
                if (MEM_WE) mem[MEM_ADDR] = MEM_WDATA;
            end else lat--;
        end else ack = 1'(($urandom % 8) == 0);
        DO_RECORD = rec; DO_PLAYBACK = play; DO_CLEAR = clr;
        SAMPLE_TICK = tick; ADC_DATA = adc; MEM_ACK = ack; MEM_RDATA = rd;

        pb = m_pend;
        enter_clr = 1'b0;
        if (tick && (m_mode == M_REC || m_mode == M_PLAY)) begin
            if (pb) m_ovr = 1'b1;
            else if (m_mode == M_REC && rec && !m_full) begin
                m_pend = 1'b1; m_we = 1'b1; m_addr = m_wcnt; m_wdata = adc;
            end else if (m_mode == M_PLAY && play && m_len != 0) begin
                m_pend = 1'b1; m_we = 1'b0; m_addr = m_ptr;
            end
        end
        if (pb && ack) begin
            m_pend = 1'b0;
            if (m_we) begin
                m_rec[m_addr] = m_wdata;
                m_len = m_addr + 1;
                if (m_addr == int'(MAXA)) m_full = 1'b1;
                else m_wcnt++;
            end else begin
                m_dac = m_rec[m_addr];
                m_ptr = (m_ptr + 1 == m_len) ? 0 : m_ptr + 1;
            end
        end
        case (m_mode)
            M_IDLE: begin
                if (clr && !m_blk) begin
                    m_mode = M_CLEAR; m_len = 0; m_full = 1'b0; m_ovr = 1'b0; enter_clr = 1'b1;
                end else if (rec) begin
                    m_mode = M_REC; m_wcnt = 0;
                end else if (play) begin
                    m_mode = M_PLAY; m_ptr = 0;
                end
            end
            M_CLEAR: m_mode = M_IDLE;
            M_REC:   if (!pb && !rec) m_mode = M_IDLE;
            M_PLAY:  if (!pb && !play) begin m_mode = M_IDLE; m_dac = 16'h0; end
            default: m_mode = M_IDLE;
        endcase
        m_blk = clr && (m_blk || enter_clr);
        @(negedge CLK);
    endtask

    vec_t tbl [21];

    initial begin
        // Record three samples, then loop them back over four ticks
        tbl[0]  = row(1,0,0,0,0,       0,0,0, 0,      0,1);
        tbl[1]  = row(1,0,1,0,0,       1,1,0, 0,      0,1);
        tbl[2]  = row(1,0,0,0,0,       1,1,0, 0,      0,1);
        tbl[3]  = row(1,0,0,1,0,       0,0,0, 0,      1,1);
        tbl[4]  = row(1,0,1,0,0,       1,1,1, 0,      1,1);
        tbl[5]  = row(1,0,0,0,0,       1,1,1, 0,      1,1);
        tbl[6]  = row(1,0,0,1,0,       0,0,0, 0,      2,1);
        tbl[7]  = row(1,0,1,0,0,       1,1,2, 0,      2,1);
        tbl[8]  = row(1,0,0,0,0,       1,1,2, 0,      2,1);
        tbl[9]  = row(1,0,0,1,0,       0,0,0, 0,      3,1);
        tbl[10] = row(0,0,0,0,0,       0,0,0, 0,      3,0);
        tbl[11] = row(0,1,0,0,0,       0,0,0, 0,      3,1);
        tbl[12] = row(0,1,1,0,0,       1,0,0, 0,      3,1);
        tbl[13] = row(0,1,0,1,'hA000,  0,0,0, 'hA000, 3,1);
        tbl[14] = row(0,1,1,0,0,       1,0,1, 'hA000, 3,1);
        tbl[15] = row(0,1,0,1,'hA001,  0,0,0, 'hA001, 3,1);
        tbl[16] = row(0,1,1,0,0,       1,0,2, 'hA001, 3,1);
        tbl[17] = row(0,1,0,1,'hA002,  0,0,0, 'hA002, 3,1);
        tbl[18] = row(0,1,1,0,0,       1,0,0, 'hA002, 3,1);
        tbl[19] = row(0,1,0,1,'hA003,  0,0,0, 'hA003, 3,1);
        tbl[20] = row(0,0,0,0,0,       0,0,0, 0,      3,0);

        RESET = 1'b1;
        DO_RECORD = 1'b0; DO_PLAYBACK = 1'b0; DO_CLEAR = 1'b0; SAMPLE_TICK = 1'b0;
        MEM_ACK = 1'b0; ADC_DATA = 16'h0; MEM_RDATA = 16'h0;
        @(negedge CLK);
        drive(0,0,0,0,0,0,0);
        chk("rst.req", 32'(MEM_REQ), 0);     chk("rst.we", 32'(MEM_WE), 0);
        chk("rst.addr", 32'(MEM_ADDR), 0);   chk("rst.wdata", 32'(MEM_WDATA), 0);
        chk("rst.dac", 32'(DAC_DATA), 0);    chk("rst.time", 32'(REC_TIME), 0);
        chk("rst.end", 32'(REC_END_TIME), 0); chk("rst.busy", 32'(BUSY), 0);
        chk("rst.full", 32'(FULL), 0);       chk("rst.ovr", 32'(OVERRUN), 0);
        RESET = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rec, tbl[i].play, 0, tbl[i].tick, tbl[i].ack, 'h1234, tbl[i].rd);
            chk($sformatf("tbl%0d.req", i), 32'(MEM_REQ), 32'(tbl[i].req));
            chk($sformatf("tbl%0d.busy", i), 32'(BUSY), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d.end", i), 32'(REC_END_TIME), 32'(tbl[i].endt));
            chk($sformatf("tbl%0d.dac", i), 32'(DAC_DATA), 32'(tbl[i].dac));
            chk($sformatf("tbl%0d.ovr", i), 32'(OVERRUN), 0);
            if (tbl[i].req) begin
                chk($sformatf("tbl%0d.we", i), 32'(MEM_WE), 32'(tbl[i].we));
                chk($sformatf("tbl%0d.addr", i), 32'(MEM_ADDR), 32'(tbl[i].addr));
                if (tbl[i].we) chk($sformatf("tbl%0d.wdata", i), 32'(MEM_WDATA), 'h1234);
            end
        end

        // Priority: clear wins, fires once while held, then record is chosen
        drive(1,1,1,0,0,0,0);
        chk("prio.busy", 32'(BUSY), 1); chk("prio.end", 32'(REC_END_TIME), 0);
        chk("prio.req", 32'(MEM_REQ), 0);
        drive(1,1,1,0,0,0,0);
        chk("prio.idle", 32'(BUSY), 0); chk("prio.req2", 32'(MEM_REQ), 0);
        drive(1,1,1,0,0,0,0);
        chk("prio.rec", 32'(BUSY), 1); chk("prio.req3", 32'(MEM_REQ), 0);
        drive(0,0,0,0,0,0,0);
        chk("prio.rel", 32'(BUSY), 0);

        // Overrun: second tick while the write is still unacknowledged
        drive(1,0,0,0,0,0,0);
        drive(1,0,0,1,0,'hBEEF,0);
        chk("ovr.req", 32'(MEM_REQ), 1); chk("ovr.wdata", 32'(MEM_WDATA), 'hBEEF);
        drive(1,0,0,1,0,'h1111,0);
        chk("ovr.flag", 32'(OVERRUN), 1); chk("ovr.hold", 32'(MEM_WDATA), 'hBEEF);
        chk("ovr.addr", 32'(MEM_ADDR), 0);
        drive(1,0,0,0,1,0,0);
        chk("ovr.ackreq", 32'(MEM_REQ), 0); chk("ovr.end", 32'(REC_END_TIME), 1);
        drive(1,0,0,0,0,0,0);
        chk("ovr.onewrite", 32'(MEM_REQ), 0);
        drive(0,0,0,0,0,0,0);
        drive(0,0,1,0,0,0,0);
        chk("clr.ovr", 32'(OVERRUN), 0); chk("clr.end", 32'(REC_END_TIME), 0);
        drive(0,0,0,0,0,0,0);

        // Full: five ticks with MAX_ADDR=3, the fifth is ignored
        drive(1,0,0,0,0,0,0);
        for (int i = 0; i < 5; i++) begin
            drive(1,0,0,1,0,i,0);
            if (i < 4) begin
                chk($sformatf("full.req%0d", i), 32'(MEM_REQ), 1);
                chk($sformatf("full.addr%0d", i), 32'(MEM_ADDR), i);
            end else chk("full.noreq", 32'(MEM_REQ), 0);
            drive(1,0,0,0,1,0,0);
        end
        chk("full.flag", 32'(FULL), 1); chk("full.end", 32'(REC_END_TIME), 4);
        chk("full.time", 32'(REC_TIME), 3); chk("full.ovr", 32'(OVERRUN), 0);
        chk("full.req", 32'(MEM_REQ), 0);
        drive(0,0,0,0,0,0,0);
        drive(0,0,1,0,0,0,0);
        chk("full.clr", 32'(FULL), 0);
        drive(0,0,0,0,0,0,0);

        // Reset during an outstanding write abandons it
        drive(1,0,0,0,0,0,0);
        drive(1,0,0,1,0,'h77,0);
        drive(1,0,0,0,1,0,0);
        chk("rmid.end1", 32'(REC_END_TIME), 1);
        drive(1,0,0,1,0,'h78,0);
        chk("rmid.req1", 32'(MEM_REQ), 1);
        RESET = 1'b1;
        drive(1,0,0,0,0,0,0);
        chk("rmid.req", 32'(MEM_REQ), 0); chk("rmid.busy", 32'(BUSY), 0);
        chk("rmid.end", 32'(REC_END_TIME), 0); chk("rmid.addr", 32'(MEM_ADDR), 0);
        RESET = 1'b0;
        drive(0,0,0,0,1,0,0);
        chk("rmid.lateack", 32'(MEM_REQ), 0); chk("rmid.lateend", 32'(REC_END_TIME), 0);
        chk("rmid.latebusy", 32'(BUSY), 0);

        // Empty playback produces no traffic
        drive(0,1,0,0,0,0,0);
        chk("empty.busy", 32'(BUSY), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0,1,0,1,0,0,'hFFFF);
            chk($sformatf("empty.req%0d", i), 32'(MEM_REQ), 0);
            chk($sformatf("empty.dac%0d", i), 32'(DAC_DATA), 0);
        end
        drive(0,0,0,0,0,0,0);

        // Playback released mid-read: the read finishes, then DAC returns to 0
        drive(1,0,0,0,0,0,0);
        drive(1,0,0,1,0,'h5A5A,0);
        drive(1,0,0,0,1,0,0);
        drive(0,0,0,0,0,0,0);
        drive(0,1,0,0,0,0,0);
        drive(0,1,0,1,0,0,0);
        chk("rel.req", 32'(MEM_REQ), 1); chk("rel.we", 32'(MEM_WE), 0);
        drive(0,0,0,0,0,0,0);
        chk("rel.hold", 32'(MEM_REQ), 1); chk("rel.busy", 32'(BUSY), 1);
        drive(0,0,0,0,1,0,'hC0DE);
        chk("rel.dac", 32'(DAC_DATA), 'hC0DE); chk("rel.done", 32'(MEM_REQ), 0);
        drive(0,0,0,0,0,0,0);
        chk("rel.idle", 32'(BUSY), 0); chk("rel.dac0", 32'(DAC_DATA), 0);

        // Randomized sessions against the model
        RESET = 1'b1;
        drive(0,0,0,0,0,0,0);
        RESET = 1'b0;
        m_mode = M_IDLE; m_len = 0; m_wcnt = 0; m_ptr = 0; m_addr = 0;
        m_full = 1'b0; m_ovr = 1'b0; m_pend = 1'b0; m_blk = 1'b0; m_we = 1'b0;
        m_wdata = 16'h0; m_dac = 16'h0; lat_on = 1'b0; lat = 0;
        for (int i = 0; i < 4; i++) m_rec[i] = 16'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        for (int s = 0; s < 80; s++) begin
            logic r, p, c;
            int len;
            r = 1'($urandom % 2);
            p = 1'($urandom % 2);
            c = 1'(($urandom % 4) == 0);
            len = $urandom_range(5, 40);
            for (int k = 0; k < len; k++)
                rstep(r, p, c, 1'(($urandom % 4) == 0), 16'($urandom));
            for (int k = 0; k < 6; k++)
                rstep(1'b0, 1'b0, 1'b0, 1'(($urandom % 4) == 0), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
